// File: rtl/score_board_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_board_pkg
// Description : Shared types and constants for the register scoreboard.
//               Holds the forwarding-select enum, the per-source select
//               struct, the in-flight table entry struct and the stage
//               indices of the EX/MEM/CMT table.
// Revision    : 1.0 - initial release
// ============================================================================
package score_board_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR   = $clog2(REG_NUM);
  localparam int SB_STAGES  = 3;
  localparam int SB_LANES   = 2;

  // Stage indices into the in-flight table (0 is the youngest stage).
  localparam int SB_EX      = 0;
  localparam int SB_MEM     = 1;
  localparam int SB_CMT     = 2;

  typedef enum logic [1:0] {
    SB_REGFILE = 2'd0,
    SB_EXECUTE = 2'd1,
    SB_MEMORY  = 2'd2,
    SB_COMMIT  = 2'd3
  } SB_SRC_SEL;

  typedef struct packed {
    SB_SRC_SEL sel;
    logic      lane;
  } SCORE_BOARD_DATA;

  typedef struct packed {
    logic                valid;
    logic [REG_ADDR-1:0] dst;
    logic                load;
  } SB_ENTRY;

  localparam int SB_DATA_W  = $bits(SCORE_BOARD_DATA);
  localparam int SB_ENTRY_W = $bits(SB_ENTRY);

  // Forwarding source that corresponds to a table stage.
  function automatic SB_SRC_SEL sb_stage_sel(input int stage);
    case (stage)
      SB_EX:   return SB_EXECUTE;
      SB_MEM:  return SB_MEMORY;
      SB_CMT:  return SB_COMMIT;
      default: return SB_REGFILE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_board_lookup.sv
`default_nettype none
// ============================================================================
// Module      : sb_lookup
// Description : Priority search of one source operand over the six in-flight
//               table entries. The youngest matching entry decides the
//               forwarding select; a youngest match on an EX-stage load is
//               reported as a load-use hazard.
// Ports       : src_addr    - source register address
//               src_used    - the source is actually read
//               entries     - flattened table, entry (stage*2+lane)
//               data        - SCORE_BOARD_DATA {sel, lane}
//               load_hazard - youngest match is a load still in EX
// Revision    : 1.0 - initial release
// ============================================================================
module sb_lookup
  import score_board_pkg::*;
(
  input  logic [REG_ADDR-1:0]                      src_addr,
  input  logic                                     src_used,
  input  logic [SB_STAGES*SB_LANES*SB_ENTRY_W-1:0] entries,
  output logic [SB_DATA_W-1:0]                     data,
  output logic                                     load_hazard
);

  SB_ENTRY         entry;
  SCORE_BOARD_DATA result;

  // Walk oldest to youngest so that the last match (the youngest) wins:
  // CMT lane0, CMT lane1, MEM lane0, MEM lane1, EX lane0, EX lane1.
  always_comb begin
    result      = '{sel: SB_REGFILE, lane: 1'b0};
    load_hazard = 1'b0;
    entry       = '0;
    if (src_used && (src_addr != '0)) begin
      for (int s = SB_STAGES - 1; s >= 0; s--) begin
        for (int l = 0; l < SB_LANES; l++) begin
          entry = entries[(s*SB_LANES + l)*SB_ENTRY_W +: SB_ENTRY_W];
          if (entry.valid && (entry.dst == src_addr)) begin
            result.sel  = sb_stage_sel(s);
            result.lane = l[0];
            load_hazard = (s == SB_EX) && entry.load;
          end
        end
      end
    end
  end

  assign data = result;

endmodule
`default_nettype wire

// File: rtl/score_board.sv
`default_nettype none
// ============================================================================
// Module      : score_board
// Description : Register scoreboard and issue scheduler for the dual-issue
//               in-order pipeline. Tracks destinations in flight through
//               EX/MEM/CMT, grants 0..2 issue-queue head candidates and
//               produces per-source forwarding selects for bypass.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               cand_valid        - head slots valid (slot 0 oldest)
//               cand_src_addr     - {s1 rt, s1 rs, s0 rt, s0 rs}
//               cand_src_used     - source actually read
//               cand_dst_addr     - destination per slot
//               cand_dst_ena      - slot writes its destination
//               cand_is_load      - result available at MEM, not EX
//               stall, flush      - pipeline hold / squash EX and issue
//               issue_number      - candidates granted this cycle
//               score_board_data  - per-source SCORE_BOARD_DATA selects
// Config      : SCORE_BOARD_DUAL_ISSUE_EN - when defined slot 1 may be
//               granted; otherwise at most one instruction issues per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module score_board
  import score_board_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cand_valid,
  input  logic [4*REG_ADDR-1:0]  cand_src_addr,
  input  logic [3:0]             cand_src_used,
  input  logic [2*REG_ADDR-1:0]  cand_dst_addr,
  input  logic [1:0]             cand_dst_ena,
  input  logic [1:0]             cand_is_load,
  input  logic                   stall,
  input  logic                   flush,
  output logic [1:0]             issue_number,
  output logic [4*SB_DATA_W-1:0] score_board_data
);

  SB_ENTRY [SB_STAGES-1:0][SB_LANES-1:0] sb_table_q;
  SB_ENTRY [SB_STAGES-1:0][SB_LANES-1:0] sb_table_d;

  logic [SB_STAGES*SB_LANES*SB_ENTRY_W-1:0] table_flat;
  logic [4*SB_DATA_W-1:0]                   lookup_data;
  logic [3:0]                               src_hazard;

  logic [REG_ADDR-1:0] dst0;
  logic [REG_ADDR-1:0] dst1;
  logic [REG_ADDR-1:0] slot1_rs;
  logic [REG_ADDR-1:0] slot1_rt;
  logic                dst0_wr;
  logic                dst1_wr;
  logic                pair_dep;
  logic                grant0;
  logic                grant1;
  SB_ENTRY             ex_lane0;
  SB_ENTRY             ex_lane1;

  assign table_flat = sb_table_q;

  for (genvar i = 0; i < 4; i++) begin : g_src_lookup
    sb_lookup u_lookup (
      .src_addr    (cand_src_addr[i*REG_ADDR +: REG_ADDR]),
      .src_used    (cand_src_used[i]),
      .entries     (table_flat),
      .data        (lookup_data[i*SB_DATA_W +: SB_DATA_W]),
      .load_hazard (src_hazard[i])
    );
  end

  assign dst0     = cand_dst_addr[0        +: REG_ADDR];
  assign dst1     = cand_dst_addr[REG_ADDR +: REG_ADDR];
  assign slot1_rs = cand_src_addr[2*REG_ADDR +: REG_ADDR];
  assign slot1_rt = cand_src_addr[3*REG_ADDR +: REG_ADDR];
  assign dst0_wr  = cand_dst_ena[0] && (dst0 != '0);
  assign dst1_wr  = cand_dst_ena[1] && (dst1 != '0);

  // Slot 1 cannot consume slot 0's result in the same issue cycle.
  assign pair_dep = dst0_wr &&
                    ((cand_src_used[2] && (slot1_rs == dst0)) ||
                     (cand_src_used[3] && (slot1_rt == dst0)));

  // rst gates the grant so nothing issues while the table is being cleared.
  assign grant0 = cand_valid[0] && !src_hazard[0] && !src_hazard[1] &&
                  !stall && !flush && !rst;

`ifdef SCORE_BOARD_DUAL_ISSUE_EN
  assign grant1 = grant0 && cand_valid[1] && !src_hazard[2] &&
                  !src_hazard[3] && !pair_dep;
`else
  logic slot1_unused;
  assign grant1       = 1'b0;
  assign slot1_unused = ^{cand_valid[1], src_hazard[3:2], pair_dep};
`endif

  assign issue_number     = {grant0 & grant1, grant0 & ~grant1};
  assign score_board_data = rst ? '0 : lookup_data;

  always_comb begin
    ex_lane0 = '0;
    ex_lane1 = '0;
    if (grant0) begin
      ex_lane0 = '{valid: dst0_wr, dst: dst0, load: cand_is_load[0]};
    end
    if (grant1) begin
      ex_lane1 = '{valid: dst1_wr, dst: dst1, load: cand_is_load[1]};
    end
  end

  // Flush advances the pipe like a normal cycle (EX still drains to MEM);
  // only new issue is squashed, which grant0 already guarantees.
  always_comb begin
    sb_table_d = sb_table_q;
    if (flush || !stall) begin
      sb_table_d[SB_CMT]    = sb_table_q[SB_MEM];
      sb_table_d[SB_MEM]    = sb_table_q[SB_EX];
      sb_table_d[SB_EX][0]  = ex_lane0;
      sb_table_d[SB_EX][1]  = ex_lane1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_table_q <= '0;
    end else begin
      sb_table_q <= sb_table_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_board.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_board
// Description : Directed, table-driven bench for score_board. Each record is
//               one cycle of candidate inputs with the hand-derived grant
//               count and forwarding selects; a short hand-written sequence
//               covers asynchronous reset in the middle of operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_board;
  import score_board_pkg::*;

`ifdef SCORE_BOARD_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  // Expected select encodings {sel[1:0], lane}.
  localparam logic [2:0] RF  = 3'd0;
  localparam logic [2:0] EX0 = 3'd2;
  localparam logic [2:0] EX1 = 3'd3;
  localparam logic [2:0] ME0 = 3'd4;
  localparam logic [2:0] ME1 = 3'd5;
  localparam logic [2:0] CM0 = 3'd6;
  localparam logic [2:0] CM1 = 3'd7;

  typedef struct {
    logic [1:0] valid;
    logic [4:0] s0, s1, s2, s3;
    logic [3:0] used;
    logic [4:0] d0, d1;
    logic [1:0] dena;
    logic [1:0] ld;
    logic       stall;
    logic       flush;
    logic [1:0] n;
    logic [2:0] e0, e1, e2, e3;
  } vec_t;

  logic                   clk;
  logic                   rst;
  logic [1:0]             cand_valid;
  logic [4*REG_ADDR-1:0]  cand_src_addr;
  logic [3:0]             cand_src_used;
  logic [2*REG_ADDR-1:0]  cand_dst_addr;
  logic [1:0]             cand_dst_ena;
  logic [1:0]             cand_is_load;
  logic                   stall;
  logic                   flush;
  logic [1:0]             issue_number;
  logic [4*SB_DATA_W-1:0] score_board_data;

  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  score_board dut (
    .clk              (clk),
    .rst              (rst),
    .cand_valid       (cand_valid),
    .cand_src_addr    (cand_src_addr),
    .cand_src_used    (cand_src_used),
    .cand_dst_addr    (cand_dst_addr),
    .cand_dst_ena     (cand_dst_ena),
    .cand_is_load     (cand_is_load),
    .stall            (stall),
    .flush            (flush),
    .issue_number     (issue_number),
    .score_board_data (score_board_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [1:0] v,
                     input logic [4:0] s0, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [4:0] s3,
                     input logic [3:0] u,
                     input logic [4:0] d0, input logic [4:0] d1,
                     input logic [1:0] de, input logic [1:0] ld,
                     input logic st, input logic fl,
                     input logic [1:0] n,
                     input logic [2:0] e0, input logic [2:0] e1,
                     input logic [2:0] e2, input logic [2:0] e3);
    vec_t t;
    t.valid = v;  t.s0 = s0; t.s1 = s1; t.s2 = s2; t.s3 = s3;
    t.used  = u;  t.d0 = d0; t.d1 = d1; t.dena = de; t.ld = ld;
    t.stall = st; t.flush = fl; t.n = n;
    t.e0 = e0; t.e1 = e1; t.e2 = e2; t.e3 = e3;
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    cand_valid    = t.valid;
    cand_src_addr = {t.s3, t.s2, t.s1, t.s0};
    cand_src_used = t.used;
    cand_dst_addr = {t.d1, t.d0};
    cand_dst_ena  = t.dena;
    cand_is_load  = t.ld;
    stall         = t.stall;
    flush         = t.flush;
  endtask

  task automatic check(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] n,
                           input logic [2:0] e0, input logic [2:0] e1,
                           input logic [2:0] e2, input logic [2:0] e3);
    check({tag, ".issue"}, {1'b0, issue_number}, {1'b0, n});
    check({tag, ".src0"}, score_board_data[0*SB_DATA_W +: SB_DATA_W], e0);
    check({tag, ".src1"}, score_board_data[1*SB_DATA_W +: SB_DATA_W], e1);
    check({tag, ".src2"}, score_board_data[2*SB_DATA_W +: SB_DATA_W], e2);
    check({tag, ".src3"}, score_board_data[3*SB_DATA_W +: SB_DATA_W], e3);
  endtask

  initial begin
    vec_t t;
    n_checks = 0;
    n_fail   = 0;

    // valid s0 s1 s2 s3 used d0 d1 dena ld stall flush | n e0 e1 e2 e3
    add(2'b00,  0,  0,  0,  0, 4'b0000,  0,  0, 2'b00, 2'b00, 0, 0,
        2'd0, RF, RF, RF, RF);
    // independent addu $3 / addu $4
    add(2'b11,  1,  2,  1,  2, 4'b1111,  3,  4, 2'b11, 2'b00, 0, 0,
        DUAL ? 2'd2 : 2'd1, RF, RF, RF, RF);
    add(2'b01,  4,  3,  0,  0, 4'b0011,  6,  0, 2'b01, 2'b00, 0, 0,
        2'd1, DUAL ? EX1 : RF, EX0, RF, RF);
    // lw $5
    add(2'b01,  3,  0,  4,  6, 4'b1101,  5,  0, 2'b01, 2'b01, 0, 0,
        2'd1, ME0, RF, DUAL ? ME1 : RF, EX0);
    // load-use on $5: one bubble, then MEM forward
    add(2'b11,  5,  3,  4,  0, 4'b0111, 10,  0, 2'b01, 2'b00, 0, 0,
        2'd0, EX0, CM0, DUAL ? CM1 : RF, RF);
    add(2'b11,  5,  3,  4,  0, 4'b0111, 10, 11, 2'b11, 2'b00, 0, 0,
        DUAL ? 2'd2 : 2'd1, ME0, RF, RF, RF);
    // slot0 writes $7, slot1 reads $7
    add(2'b11, 10,  5,  7, 11, 4'b1111,  7, 12, 2'b11, 2'b00, 0, 0,
        2'd1, EX0, CM0, RF, DUAL ? EX1 : RF);
    add(2'b01,  7, 11,  0,  0, 4'b0011, 12,  0, 2'b01, 2'b00, 0, 0,
        2'd1, EX0, DUAL ? ME1 : RF, RF, RF);
    // writes to $0 (including loads) leave nothing in flight
    add(2'b11, 12,  7, 10, 11, 4'b1111,  0,  0, 2'b11, 2'b11, 0, 0,
        DUAL ? 2'd2 : 2'd1, EX0, ME0, CM0, DUAL ? CM1 : RF);
    add(2'b11,  0,  0,  0, 12, 4'b1111,  8,  0, 2'b01, 2'b00, 0, 0,
        DUAL ? 2'd2 : 2'd1, RF, RF, RF, ME0);
    // stall two cycles with $8 in EX
    add(2'b01,  8, 12,  0,  0, 4'b0011,  9,  0, 2'b01, 2'b00, 1, 0,
        2'd0, EX0, CM0, RF, RF);
    add(2'b01,  8, 12,  0,  0, 4'b0011,  9,  0, 2'b01, 2'b00, 1, 0,
        2'd0, EX0, CM0, RF, RF);
    add(2'b01,  8, 12,  0,  0, 4'b0011,  9,  0, 2'b01, 2'b00, 0, 0,
        2'd1, EX0, CM0, RF, RF);
    // flush with $9 in EX; new $14 must not enter
    add(2'b01,  9,  8,  0,  0, 4'b0011, 14,  0, 2'b01, 2'b00, 0, 1,
        2'd0, EX0, ME0, RF, RF);
    add(2'b01,  9, 14,  8,  0, 4'b0111,  0,  0, 2'b00, 2'b00, 0, 0,
        2'd1, ME0, RF, CM0, RF);
    // flush together with stall: flush wins, table advances
    add(2'b01,  9,  0,  0,  0, 4'b0001,  0,  0, 2'b00, 2'b00, 1, 1,
        2'd0, CM0, RF, RF, RF);
    add(2'b01,  9,  0,  0,  0, 4'b0001,  0,  0, 2'b00, 2'b00, 0, 0,
        2'd1, RF, RF, RF, RF);
    // WAW: both lanes write $20, lane 1 wins the lookup
    add(2'b11,  0,  0,  0,  0, 4'b0000, 20, 20, 2'b11, 2'b00, 0, 0,
        DUAL ? 2'd2 : 2'd1, RF, RF, RF, RF);
    add(2'b00, 20,  0,  0,  0, 4'b0001,  0,  0, 2'b00, 2'b00, 0, 0,
        2'd0, DUAL ? EX1 : EX0, RF, RF, RF);
    // lw $21, then slot1 load-use (slot0 unaffected; unused src no hazard)
    add(2'b01, 20,  0,  0,  0, 4'b0001, 21,  0, 2'b01, 2'b01, 0, 0,
        2'd1, DUAL ? ME1 : ME0, RF, RF, RF);
    add(2'b11,  0, 21, 21,  0, 4'b0100, 22, 23, 2'b11, 2'b00, 0, 0,
        2'd1, RF, RF, EX0, RF);

    // Reset: outputs forced idle while rst is high, even with a valid slot.
    rst = 1'b0;
    t = vecs[1];
    drive(t);
    #1 rst = 1'b1;
    #1 check_all("reset", 2'd0, RF, RF, RF, RF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2 check_all($sformatf("v%0d", i), vecs[i].n,
                   vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
      @(posedge clk);
      #1;
    end

    // Table now: EX0=$22, MEM0=$21 (load). Async reset mid-cycle.
    cand_valid    = 2'b01;
    cand_src_addr = {5'd0, 5'd0, 5'd21, 5'd22};
    cand_src_used = 4'b0011;
    cand_dst_addr = {5'd0, 5'd25};
    cand_dst_ena  = 2'b01;
    cand_is_load  = 2'b00;
    stall         = 1'b0;
    flush         = 1'b0;
    #1 check_all("pre_rst", 2'd1, EX0, ME0, RF, RF);
    #1 rst = 1'b1;
    #1 check_all("async_rst", 2'd0, RF, RF, RF, RF);
    @(posedge clk);
    #1 check_all("in_rst", 2'd0, RF, RF, RF, RF);
    #1 rst = 1'b0;
    #1 check_all("post_rst", 2'd1, RF, RF, RF, RF);
    @(posedge clk);
    #1;
    cand_valid    = 2'b00;
    cand_src_addr = {5'd0, 5'd0, 5'd0, 5'd25};
    cand_src_used = 4'b0001;
    #1 check_all("first_grant", 2'd0, EX0, RF, RF, RF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
